// File: rtl/uart_fifo_if.sv
// Bundles the FIFO's request, data and status signals into one interface.
// The master side issues writes, reads and error clears; the slave side is
// the FIFO, which returns popped data and occupancy/error status.
interface uart_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr, w_data, rd, clr_err,
    input  r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, w_data, rd, clr_err,
    output r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous single-clock FIFO for buffering UART bytes.
// Read data is registered: a word popped at one edge is presented with
// r_valid high during the following cycle. All status flags are decoded
// from the registered occupancy count, so no input reaches an output
// combinationally. Overflow/underflow are sticky until clr_err.
module uart_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 1
) (
  input logic        clk,
  input logic        reset,
  uart_fifo_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  overflow;
  logic                  underflow;

  logic full_flag;
  logic empty_flag;
  logic rd_accept;
  logic wr_accept;
  logic overflow_event;
  logic underflow_event;

  // Occupancy flags come straight from the count register.
  assign full_flag  = (count == DEPTH_CNT);
  assign empty_flag = (count == '0);

  // A read needs a stored word; a write needs space, or a read in the
  // same cycle that frees the slot (full + wr + rd keeps count at DEPTH).
  // On an empty FIFO the read is rejected even if a write arrives, so
  // there is no write-through bypass.
  assign rd_accept       = bus.rd & ~empty_flag;
  assign wr_accept       = bus.wr & (~full_flag | rd_accept);
  assign overflow_event  = bus.wr & ~wr_accept;
  assign underflow_event = bus.rd & ~rd_accept;

  // Storage array: no reset needed, only written locations are ever read.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[wp] <= bus.w_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_accept) begin
        wp <= wp + 1'b1;
      end
      if (rd_accept) begin
        rp <= rp + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered read port: r_data holds its value unless a pop occurs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_accept;
      if (rd_accept) begin
        r_data <= mem[rp];
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (overflow_event) begin
        overflow <= 1'b1;
      end else if (bus.clr_err) begin
        overflow <= 1'b0;
      end
      if (underflow_event) begin
        underflow <= 1'b1;
      end else if (bus.clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  assign bus.r_data       = r_data;
  assign bus.r_valid      = r_valid;
  assign bus.count        = count;
  assign bus.full         = full_flag;
  assign bus.empty        = empty_flag;
  assign bus.almost_full  = (count >= AF_CNT);
  assign bus.almost_empty = (count <= AE_CNT);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo with default geometry (8 x 16).
// Stimulus tasks keep a reference queue of stored words; every accepted
// pop pushes the expected word into a scoreboard that an independent
// negedge monitor drains whenever the FIFO raises r_valid.
module tb_uart_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  uart_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uart_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] sb_q[$];
  bit            exp_valid = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  bit            exp_ovf = 1'b0;
  bit            exp_udf = 1'b0;
  bit            mon_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Compare every status output and the held read data against the model.
  task automatic checkOutput();
    int n;
    n = model_q.size();
    check("count", 32'(bus.count), 32'(n));
    check("full", 32'(bus.full), 32'(n == DEPTH));
    check("empty", 32'(bus.empty), 32'(n == 0));
    check("almost_full", 32'(bus.almost_full), 32'(n >= AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
    check("underflow", 32'(bus.underflow), 32'(exp_udf));
    check("r_data_hold", 32'(bus.r_data), 32'(exp_rdata));
  endtask

  // One clock of requests; updates the reference model at the edge.
  task automatic applyStimulus(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit rd_acc;
    bit wr_acc;
    bus.wr      = w;
    bus.w_data  = d;
    bus.rd      = r;
    bus.clr_err = c;
    rd_acc = r && (model_q.size() != 0);
    wr_acc = w && ((model_q.size() < DEPTH) || rd_acc);
    @(posedge clk);
    exp_valid = rd_acc;
    if (rd_acc) begin
      exp_rdata = model_q.pop_front();
      sb_q.push_back(exp_rdata);
    end
    if (wr_acc) model_q.push_back(d);
    if (w && !wr_acc) exp_ovf = 1'b1;
    else if (c) exp_ovf = 1'b0;
    if (r && !rd_acc) exp_udf = 1'b1;
    else if (c) exp_udf = 1'b0;
    #1;
    checkOutput();
  endtask

  // Reset cycle with requests optionally asserted, which must be discarded.
  task automatic doReset(input bit junk);
    reset       = 1'b1;
    bus.wr      = junk;
    bus.w_data  = 8'hEE;
    bus.rd      = junk;
    bus.clr_err = junk;
    @(posedge clk);
    model_q.delete();
    exp_valid = 1'b0;
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
    #1;
    reset   = 1'b0;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.clr_err = 1'b0;
    mon_en  = 1'b1;
    checkOutput();
  endtask

  // Monitor: checks r_valid timing and pops the scoreboard on each valid word.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("r_valid", 32'(bus.r_valid), 32'(exp_valid));
        if (bus.r_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            check("r_valid_unexpected", 32'(bus.r_data), 32'hFFFF_FFFF);
          end else begin
            check("r_data_sb", 32'(bus.r_data), 32'(sb_q.pop_front()));
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence followed by a short random mix.
  initial begin
    bus.wr      = 1'b0;
    bus.w_data  = '0;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    doReset(1'b1);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);

    // Overflow and clear.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Overflow coinciding with clr_err: flag stays set.
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous write and read while full.
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);

    // Drain all 16: expect 0x02..0x10 then 0x55.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Underflow on empty, then write+read on empty.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Random mix across the pointer wrap.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'b0);
    end
    while (model_q.size() != 0) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-operation discards stored words.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    doReset(1'b1);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, pointer width; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-2).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 wr  input  1  write request.
REQ-008 w_data  input  DATA_WIDTH  write data, sampled with wr.
REQ-009 rd  input  1  read (pop) request.
REQ-010 r_data  output  DATA_WIDTH  registered read data.
REQ-011 r_valid  output  1  one-cycle pulse: r_data holds a newly popped word.
REQ-012 full, empty  output  1 each  occupancy flags.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.
REQ-016 clr_err  input  1  clears overflow and underflow.

Function
REQ-017 Storage: DEPTH x DATA_WIDTH array, write pointer wp, read pointer rp, both ADDR_WIDTH bits; pointers wrap DEPTH-1 -> 0 with no special case.
REQ-018 Write accepted iff wr=1 and (full=0 or rd accepted same cycle): mem[wp] <= w_data, wp <= wp+1.
REQ-019 Read accepted iff rd=1 and empty=0: r_data <= mem[rp], rp <= rp+1, r_valid <= 1 next cycle; otherwise r_valid <= 0 and r_data holds.
REQ-020 Read latency: word popped at edge N appears on r_data with r_valid=1 during cycle N+1.
REQ-021 count update: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-022 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); all decoded from registered count, no input-to-output combinational path.
REQ-023 Full with wr=1 and rd=1: both accepted, count stays DEPTH, no overflow.
REQ-024 Empty with wr=1 and rd=1: write accepted, read rejected, count becomes 1, underflow set, r_valid=0 next cycle (no write-through bypass).
REQ-025 wr=1 while full and no read accepted: write dropped, memory and wp unchanged, overflow <= 1.
REQ-026 rd=1 while empty: read dropped, rp and r_data unchanged, underflow <= 1.
REQ-027 overflow/underflow remain 1 until clr_err=1; if clr_err and a new error coincide, the error flag is 1 after the edge (set wins).
REQ-028 Memory contents need no reset; no output may depend on an unwritten location.

Reset
REQ-029 reset=1 at an edge: wp=0, rp=0, count=0, r_data=0, r_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0.
REQ-030 reset has priority over wr, rd and clr_err in the same cycle; requests that cycle are discarded.
REQ-031 reset mid-operation discards all stored words; first read after reset returns the first word written after reset.

Verification (defaults DATA_WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=1)
REQ-032 Write 0x01..0x10 (16 words) -> full=1, count=16, almost_full=1 from count=14; 16 reads return 0x01..0x10 in order, each r_valid one cycle after rd, empty=1 at end.
REQ-033 Full, extra wr 0xAA -> overflow=1, count=16, subsequent reads never return 0xAA; clr_err -> overflow=0.
REQ-034 Empty, rd=1 -> underflow=1, r_valid=0, r_data unchanged; wr+rd same cycle on empty -> count=1, underflow=1.
REQ-035 Full, wr 0x55 + rd together -> count stays 16, popped word is oldest, 0x55 read last; 40 mixed random ops cross pointer wrap with data matching a reference queue.
REQ-036 Write 5 words, assert reset -> count=0, empty=1, r_data=0, flags 0; write 0x77 then read -> r_data=0x77.
REQ-037 clr_err and overflow-causing write in same cycle -> overflow=1 after edge.
